inst_prefetch: RTL
==================

INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 Parameter PC_RESET, 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter DEPTH, 4, buffer entries; SHALL be a power of two, 2 to 16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mem_req  output  1  fetch request to the instruction ROM this cycle.
REQ-006 mem_addr  output  32  byte address of the fetch; bits[1:0] always 0.
REQ-007 mem_rdata  input  32  ROM data, valid exactly one cycle after mem_req was high.
REQ-008 redirect  input  1  core branch/jump/trap; flushes the buffer.
REQ-009 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-010 inst_valid  output  1  head entry available to the core.
REQ-011 inst  output  32  head instruction.
REQ-012 inst_pc  output  32  address of the head instruction.
REQ-013 inst_ready  input  1  core consumes the head when inst_valid and inst_ready are both 1.

Function
REQ-014 Storage SHALL be a first-word-fall-through FIFO of {pc, inst} pairs; inst and inst_pc SHALL reflect the head combinationally from registers.
REQ-015 inst_valid SHALL equal (count != 0).
REQ-016 fetch_pc register: mem_addr SHALL equal fetch_pc; fetch_pc SHALL advance by 4, wrapping modulo 2^32, on every cycle mem_req=1.
REQ-017 mem_req SHALL be 1 iff redirect=0 and count + inflight < DEPTH, where inflight (0/1) marks a request issued last cycle.
REQ-018 When inflight=1 and that request was not squashed, the buffer SHALL push {mem_addr of the request, mem_rdata} this cycle.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged; the REQ-017 issue rule guarantees no overflow; a pop when empty SHALL never occur.
REQ-020 Redirect cycle: count, head and tail SHALL clear on the next edge; fetch_pc <= {redirect_pc[31:2],2'b00}; any inflight response arriving next cycle SHALL be dropped; inst_valid SHALL be 0 in the cycle after redirect.
REQ-021 A redirect coinciding with a pop or a push: the redirect SHALL win, and neither the pop nor the push SHALL take effect.
REQ-022 Latency: the first request issues in the cycle after redirect (or reset release); inst_valid SHALL rise 2 cycles after that issue.
REQ-023 Steady state with inst_ready=1 continuously SHALL deliver one instruction per cycle.
REQ-024 Pointers SHALL be log2(DEPTH) bits, wrapping naturally; count SHALL be log2(DEPTH)+1 bits.

Reset
REQ-025 On rst=1, asynchronously: fetch_pc=PC_RESET, count=0, pointers=0, inflight=0, squash=0.
REQ-026 During reset, outputs SHALL be: mem_req=0, inst_valid=0, mem_addr=PC_RESET, inst=0, inst_pc=0.
REQ-027 FIFO storage contents SHALL be don't-care after reset; outputs SHALL be masked to 0 when empty.
REQ-028 Reset asserted mid-fetch SHALL discard the inflight response; after release, the sequence SHALL restart at PC_RESET.

Structure
REQ-029 The shared constants package SHALL hold XLEN=32, ILEN=32, the PC_RESET default, and the DEPTH default.
REQ-030 One sub-module, prefetch_fifo (parameterised width/depth, push/pop/flush, count out), SHALL hold the storage; inst_prefetch holds fetch_pc, inflight, squash and the issue logic.

Verification
REQ-031 Reset release, inst_ready=1 -> mem_addr 0x0,0x4,0x8 on consecutive cycles; inst_valid first high 2 cycles after the first request, with inst_pc=0x0.
REQ-032 inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, count=4, mem_req=0; inst_ready=1 -> in-order delivery of 0x0..0xC, no loss or duplicate.
REQ-033 redirect=1, redirect_pc=0x103 while an inflight request exists and the buffer is full -> next cycle inst_valid=0, mem_addr=0x100, stale response dropped; first valid inst_pc=0x100.
REQ-034 redirect coinciding with a pop -> pop ignored; no entry from the old stream appears afterwards.
REQ-035 redirect_pc=0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
REQ-036 rst pulsed asynchronously mid-stream, between edges -> outputs zero immediately; after release, fetching restarts at PC_RESET.

Source files
------------

// File: rtl/inst_prefetch_pkg.sv
// Shared constants for the instruction prefetch block.
// Contents: XLEN/ILEN widths, default reset PC, default buffer depth,
// the fetch step, and a helper that word-aligns a program counter.
package inst_prefetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam int              DEPTH_DEFAULT    = 4;

  localparam logic [XLEN-1:0] FETCH_STEP = 32'd4;

  // Instructions are word aligned; the low two address bits are forced to 0.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_prefetch_fifo.sv
// prefetch_fifo: first-word-fall-through FIFO holding {pc, inst} pairs.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write an entry (ignored during flush)
//   pop           remove the head (ignored during flush or when empty)
//   flush         empty the FIFO on the next edge
//   rdata         head entry, combinational from registers, 0 when empty
//   count         number of valid entries (0..DEPTH)
module prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;
  logic             not_empty;

  assign not_empty = (count != '0);
  // Flush wins over any simultaneous push or pop.
  assign do_push   = push & ~flush;
  assign do_pop    = pop & ~flush & not_empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale contents are hidden by the empty mask below.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = not_empty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_prefetch.sv
// inst_prefetch: fetches sequential instructions from a one-cycle-latency
// ROM into a small FWFT buffer and presents them to the core.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mem_req, mem_addr   ROM request and word-aligned byte address
//   mem_rdata           ROM data, valid the cycle after mem_req
//   redirect,           flush and restart fetching at redirect_pc
//   redirect_pc
//   inst_valid, inst,   head of the buffer and its address
//   inst_pc
//   inst_ready          core accepts the head
// Handshake: the core consumes the head in any cycle where inst_valid and
// inst_ready are both 1; inst/inst_pc are stable while inst_valid=1 and
// inst_ready=0. A redirect in the same cycle cancels the consumption.
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int              DEPTH    = DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic [ILEN-1:0] mem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int             CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_LIM = (CW+1)'(DEPTH);

  logic [XLEN-1:0]      fetch_pc;
  logic [XLEN-1:0]      req_pc;     // address of the request now in flight
  logic                 inflight;
  logic                 squash;
  logic [CW-1:0]        count;
  logic [CW:0]          occupancy;
  logic                 push;
  logic                 pop;
  logic [XLEN+ILEN-1:0] head;

  // Entries held plus the one response still on its way: issuing only while
  // this is below DEPTH guarantees the buffer never overflows.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};

  assign mem_req    = ~rst & ~redirect & (occupancy < DEPTH_LIM);
  assign mem_addr   = fetch_pc;
  assign inst_valid = (count != '0);

  // A redirect kills both the response landing now and the core's pop.
  assign push = inflight & ~squash & ~redirect;
  assign pop  = inst_valid & inst_ready & ~redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= PC_RESET;
      req_pc   <= '0;
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else begin
      inflight <= mem_req;
      // The response slot following a redirect always belongs to the old
      // stream; redirect cycles never issue, but squash keeps it dropped.
      squash   <= redirect;
      if (mem_req) req_pc <= fetch_pc;
      if (redirect)     fetch_pc <= align_pc(redirect_pc);
      else if (mem_req) fetch_pc <= fetch_pc + FETCH_STEP;
    end
  end

  prefetch_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({req_pc, mem_rdata}),
    .rdata (head),
    .count (count)
  );

  assign inst_pc = head[XLEN+ILEN-1:ILEN];
  assign inst    = head[ILEN-1:0];

endmodule
